door: RTL and testbench
=======================

DOOR -- requirements
Module: door

Interface
REQ-001 Parameter MAX_TRAVEL, default 1000, maximum clock cycles one travel (up or down) may last; used only when DOOR_TIMEOUT_EN is defined.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 UP_max  input  1  limit sensor; 1 = door fully open (top).
REQ-005 activate  input  1  user button; level input, acted on at its rising edge only.
REQ-006 DN_max  input  1  limit sensor; 1 = door fully closed (bottom).
REQ-007 UP_m  output  1  up-motor drive; 1 = raise door.
REQ-008 DN_m  output  1  down-motor drive; 1 = lower door.

Function
REQ-009 Moore FSM, three states: IDLE, MV_UP, MV_DN; UP_m = 1 only in MV_UP, DN_m = 1 only in MV_DN, both decoded from the registered state.
REQ-010 activate registered each cycle into activate_q; act_pulse = activate & ~activate_q.
REQ-011 IDLE: act_pulse & UP_max & ~DN_max -> MV_DN.
REQ-012 IDLE: act_pulse & DN_max & ~UP_max -> MV_UP.
REQ-013 IDLE: act_pulse with both sensors 0 (mid-travel stop) -> MV_DN; with both sensors 1 (sensor fault) -> stay IDLE.
REQ-014 MV_UP: UP_max = 1 -> IDLE; else act_pulse -> IDLE (user stop); else stay.
REQ-015 MV_DN: DN_max = 1 -> IDLE; else act_pulse -> IDLE (user stop); else stay.
REQ-016 Limit-sensor check has priority over act_pulse when both occur in the same cycle.
REQ-017 Latency: act_pulse sampled at edge N gives motor output 1 immediately after edge N; limit sensor sampled at edge M gives motor output 0 immediately after edge M.
REQ-018 UP_m and DN_m are never 1 at the same time.
REQ-019 Holding activate high after a completed travel does not start a new travel; a new rising edge is required.
REQ-020 Unused state encodings -> IDLE on next edge.

Reset
REQ-021 rst = 1 at a rising edge: state = IDLE, activate_q = 0, travel counter = 0; UP_m = 0, DN_m = 0 from that edge on.
REQ-022 Reset mid-travel stops the motor immediately after that edge; rst has priority over all inputs.
REQ-023 activate already high when rst is released counts as a rising edge on the first cycle after reset.

Configuration
REQ-024 Macro DOOR_TIMEOUT_EN defined: counter clears on entry to MV_UP/MV_DN and increments each cycle in motion; when the count reaches MAX_TRAVEL-1 without a limit sensor, the next state is IDLE (motors off).
REQ-025 Macro DOOR_TIMEOUT_EN not defined: no counter is implemented, and travel continues until a limit sensor or act_pulse occurs.

Verification
REQ-026 Reset, then UP_max=1, DN_max=0, activate 0->1 -> after 1 edge DN_m=1, UP_m=0; DN_max=1 -> after 1 edge DN_m=0.
REQ-027 Reset, then DN_max=1, UP_max=0, activate 0->1 -> UP_m=1, DN_m=0; UP_max=1 -> UP_m=0.
REQ-028 Reset, then UP_max=1, activate=0 for 10 cycles -> UP_m=0, DN_m=0 throughout.
REQ-029 Start MV_UP, activate high for one more cycle only, then a second activate 0->1 mid-travel -> UP_m=0 on the next edge; UP_max=DN_max=1 with activate 0->1 -> no motion.
REQ-030 Start MV_DN, assert rst for 1 cycle mid-travel -> DN_m=0 after that edge; with DOOR_TIMEOUT_EN and MAX_TRAVEL=8, travel with no sensor -> DN_m=1 for exactly 8 cycles, then 0.

Source files
------------

// File: rtl/door.sv
// Garage-door controller: Moore FSM that drives the up/down motors from a push button and two limit sensors.
// Optional travel timeout is built only when DOOR_TIMEOUT_EN is defined.
module door #(
  parameter int unsigned MAX_TRAVEL = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic UP_max,
  input  logic activate,
  input  logic DN_max,
  output logic UP_m,
  output logic DN_m
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MV_UP = 2'd1;
  localparam logic [1:0] S_MV_DN = 2'd2;

  logic [1:0] r_state;
  logic [1:0] w_next;
  logic       r_activate_q;
  logic       w_act_pulse;
  logic       w_timeout;

  assign w_act_pulse = activate & ~r_activate_q;

`ifdef DOOR_TIMEOUT_EN
  localparam int unsigned CW = (MAX_TRAVEL > 2) ? $clog2(MAX_TRAVEL) : 1;
  logic [CW-1:0] r_travel_cnt;

  // Held at zero while idle, so each travel starts counting from zero.
  always_ff @(posedge clk) begin
    if (rst || r_state == S_IDLE) begin
      r_travel_cnt <= '0;
    end else begin
      r_travel_cnt <= r_travel_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_travel_cnt == CW'(MAX_TRAVEL - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_act_pulse && !(UP_max && DN_max)) begin
          // Door at bottom goes up; at top or stopped mid-way goes down.
          w_next = (DN_max && !UP_max) ? S_MV_UP : S_MV_DN;
        end
      end
      S_MV_UP: begin
        if (UP_max || w_act_pulse || w_timeout) begin
          w_next = S_IDLE;
        end
      end
      S_MV_DN: begin
        if (DN_max || w_act_pulse || w_timeout) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_activate_q <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_activate_q <= activate;
    end
  end

  assign UP_m = (r_state == S_MV_UP);
  assign DN_m = (r_state == S_MV_DN);

endmodule

// File: tb/tb_door.sv
// Self-checking bench for door: vector table, directed corner sequences and randomized run vs a reference model.
module tb_door;

  localparam int unsigned MAXT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic UP_max = 1'b0;
  logic activate = 1'b0;
  logic DN_max = 1'b0;
  logic UP_m;
  logic DN_m;

  int checks = 0;
  int failures = 0;

  door #(.MAX_TRAVEL(MAXT)) dut (
    .clk(clk), .rst(rst), .UP_max(UP_max), .activate(activate),
    .DN_max(DN_max), .UP_m(UP_m), .DN_m(DN_m)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r, up, dn, act;
    logic e_up, e_dn;
  } vec_t;

  // Reference model: direction of motion (+1 up, -1 down, 0 still) and cycles travelled.
  int m_dir = 0;
  int m_trav = 0;
  logic m_prev = 1'b0;

  task automatic model_edge();
    logic pulse;
    bit tmo;
    pulse = activate && !m_prev;
`ifdef DOOR_TIMEOUT_EN
    tmo = (m_trav == int'(MAXT) - 1);
`else
    tmo = 1'b0;
`endif
    if (rst) begin
      m_dir = 0; m_trav = 0; m_prev = 1'b0;
    end else begin
      if (m_dir == 0) begin
        if (pulse && !(UP_max && DN_max)) begin
          m_dir = DN_max ? 1 : -1;
          m_trav = 0;
        end
      end else if ((m_dir > 0 && UP_max) || (m_dir < 0 && DN_max) || pulse || tmo) begin
        m_dir = 0;
      end else begin
        m_trav++;
      end
      m_prev = activate;
    end
  endtask

  task automatic check(input string name, input logic eu, input logic ed);
    checks++;
    if (UP_m !== eu || DN_m !== ed) begin
      failures++;
      $display("FAIL %s: UP_m=%b DN_m=%b expected UP_m=%b DN_m=%b", name, UP_m, DN_m, eu, ed);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic up, input logic dn, input logic act);
    rst = r; UP_max = up; DN_max = dn; activate = act;
  endtask

  vec_t tbl[19];
  int cnt;

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    #2;
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].r, tbl[i].up, tbl[i].dn, tbl[i].act);
      step();
      check($sformatf("vec%0d", i), tbl[i].e_up, tbl[i].e_dn);
    end

    // Idle at top with no button: motors stay off.
    drive(1'b1, 1'b0, 1'b0, 1'b0); step();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_top", 1'b0, 1'b0);
    end

    // Up travel, button held one extra cycle, second press stops; then sensor fault ignores press.
    drive(1'b1, 1'b0, 1'b0, 1'b0); step();
    drive(1'b0, 1'b0, 1'b1, 1'b1); step(); check("up_start", 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1); step(); check("up_hold", 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0); step(); check("up_release", 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1); step(); check("up_user_stop", 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0); step(); check("fault_idle", 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1); step(); check("fault_press", 1'b0, 1'b0);

    // Reset mid down-travel.
    drive(1'b1, 1'b0, 1'b0, 1'b0); step();
    drive(1'b0, 1'b1, 1'b0, 1'b1); step(); check("dn_start", 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0); step(); check("dn_moving", 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0); step(); check("dn_reset", 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0); step(); check("after_reset", 1'b0, 1'b0);

    // Unbounded down travel: length depends on the timeout build option.
    drive(1'b1, 1'b0, 1'b0, 1'b0); step();
    drive(1'b0, 1'b1, 1'b0, 1'b1); step();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    cnt = 0;
    for (int i = 0; i < 40 && DN_m === 1'b1; i++) begin
      cnt++;
      step();
    end
    checks++;
`ifdef DOOR_TIMEOUT_EN
    if (cnt != int'(MAXT)) begin
      failures++;
      $display("FAIL timeout_len: DN_m high %0d cycles, expected %0d", cnt, MAXT);
    end
`else
    if (cnt != 40) begin
      failures++;
      $display("FAIL no_timeout_len: DN_m high %0d cycles, expected 40", cnt);
    end
`endif

    // Randomized run against the model.
    drive(1'b1, 1'b0, 1'b0, 1'b0); step();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
      step();
      check($sformatf("rand%0d", i), (m_dir > 0), (m_dir < 0));
      checks++;
      if (UP_m === 1'b1 && DN_m === 1'b1) begin
        failures++;
        $display("FAIL excl%0d: UP_m=%b DN_m=%b, both must not be 1", i, UP_m, DN_m);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
